// File: rtl/renode_apb3_bridge_pkg.sv
// Shared types for the APB3 requester bridge: FSM state encoding,
// default-width command/response records and a counter sizing helper.
package renode_apb3_bridge_pkg;

  localparam int ADDR_WIDTH = 20;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_SETUP  = 2'd1,
    STATE_ACCESS = 2'd2
  } state_t;

  // Command entry at the default widths; the bridge declares a local copy
  // sized by its own parameters so non-default widths stay consistent.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } rsp_t;

  // Bits needed to count from 0 up to and including limit (min 1 bit).
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/renode_apb3_requester_bridge_if.sv
// Command stream, response stream and APB3 manager signals of the bridge.
// master: the bridge itself; slave: the requester/completer environment.
interface renode_apb3_requester_bridge_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [AddressWidth-1:0] cmd_addr;
  logic                    cmd_write;
  logic [DataWidth-1:0]    cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;
  logic                    rsp_timeout;

  logic [AddressWidth-1:0] paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
           pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
           pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/renode_apb3_bridge_fifo.sv
// Synchronous command FIFO. Head is read combinationally from the storage
// array so a pop in IDLE can load the APB registers on the same edge.
// Pointers carry an extra wrap bit to tell full from empty.
module renode_apb3_bridge_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth:0] PtrOne = {{PtrWidth{1'b0}}, 1'b1};

  logic [Width-1:0]  mem [Depth];
  logic [PtrWidth:0] wr_ptr_reg;
  logic [PtrWidth:0] rd_ptr_reg;

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[PtrWidth-1:0]] <= push_data;
    end
  end

  // Pointer update; push and pop in the same cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrOne;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrOne;
    end
  end

  assign head  = mem[rd_ptr_reg[PtrWidth-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PtrWidth] != rd_ptr_reg[PtrWidth]) &&
                 (wr_ptr_reg[PtrWidth-1:0] == rd_ptr_reg[PtrWidth-1:0]);
endmodule

// File: rtl/renode_apb3_requester_bridge.sv
// Valid/ready command stream to APB3 manager bridge with a command FIFO,
// single-entry response register and per-transfer wait-state timeout.
module renode_apb3_requester_bridge
  import renode_apb3_bridge_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int FifoDepth     = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic clk,
  input  logic rst,
  renode_apb3_requester_bridge_if.master bus
);
  typedef struct packed {
    logic [AddressWidth-1:0] addr;
    logic                    write;
    logic [DataWidth-1:0]    wdata;
  } cmd_entry_t;

  localparam int CntWidth = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] WaitLimit = CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  cmd_entry_t push_entry;
  cmd_entry_t head_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       ready_reg;

  state_t state_reg;
  state_t state_next;
  logic   complete;
  logic   abort;
  logic   timeout_hit;

  logic [CntWidth-1:0]     wait_cnt_reg;
  logic [AddressWidth-1:0] paddr_reg;
  logic                    pwrite_reg;
  logic [DataWidth-1:0]    pwdata_reg;
  logic                    rsp_valid_reg;
  logic [DataWidth-1:0]    rsp_rdata_reg;
  logic                    rsp_error_reg;
  logic                    rsp_timeout_reg;

  // ready_reg keeps cmd_ready low throughout reset without a path from rst.
  assign bus.cmd_ready    = ready_reg && !fifo_full;
  assign push             = bus.cmd_valid && bus.cmd_ready;
  assign push_entry.addr  = bus.cmd_addr;
  assign push_entry.write = bus.cmd_write;
  assign push_entry.wdata = bus.cmd_wdata;

  renode_apb3_bridge_fifo #(
    .Depth (FifoDepth),
    .Width ($bits(cmd_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The counter holds the number of pready-low ACCESS cycles seen so far;
  // abort fires in the ACCESS cycle where it already equals the limit.
  assign timeout_hit = TimeoutEn && (wait_cnt_reg == WaitLimit);

  // Next-state and transfer-event decode.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      STATE_IDLE: begin
        if (!fifo_empty && !rsp_valid_reg) begin
          pop        = 1'b1;
          state_next = STATE_SETUP;
        end
      end
      STATE_SETUP: state_next = STATE_ACCESS;
      STATE_ACCESS: begin
        if (bus.pready) begin
          complete   = 1'b1;
          state_next = STATE_IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  // FSM state register and command-acceptance enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STATE_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
    end
  end

  // APB address/direction/data: loaded on pop, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
    end else if (pop) begin
      paddr_reg  <= head_entry.addr;
      pwrite_reg <= head_entry.write;
      pwdata_reg <= head_entry.wdata;
    end
  end

  // Wait-state counter: cleared in SETUP, counts pready-low ACCESS cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == STATE_SETUP) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == STATE_ACCESS && !bus.pready) begin
      wait_cnt_reg <= wait_cnt_reg + CntOne;
    end
  end

  // Single-entry response register; fields only change when loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_error_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else if (complete) begin
      rsp_valid_reg   <= 1'b1;
      rsp_rdata_reg   <= pwrite_reg ? '0 : bus.prdata;
      rsp_error_reg   <= bus.pslverr;
      rsp_timeout_reg <= 1'b0;
    end else if (abort) begin
      rsp_valid_reg   <= 1'b1;
      rsp_rdata_reg   <= '0;
      rsp_error_reg   <= 1'b1;
      rsp_timeout_reg <= 1'b1;
    end else if (rsp_valid_reg && bus.rsp_ready) begin
      rsp_valid_reg   <= 1'b0;
    end
  end

  assign bus.psel        = (state_reg != STATE_IDLE);
  assign bus.penable     = (state_reg == STATE_ACCESS);
  assign bus.paddr       = paddr_reg;
  assign bus.pwrite      = pwrite_reg;
  assign bus.pwdata      = pwdata_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_error   = rsp_error_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
endmodule

// File: tb/tb_renode_apb3_requester_bridge.sv
// Bench for the APB3 requester bridge: table of single transfers against a
// configurable completer, plus FIFO back-pressure and mid-transfer reset.
module tb_renode_apb3_requester_bridge;
  import renode_apb3_bridge_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  renode_apb3_requester_bridge_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  renode_apb3_requester_bridge #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .FifoDepth    (4),
    .TimeoutCycles(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Completer configuration: cfg_wait pready-low ACCESS cycles before
  // pready (negative = never ready); prdata is cfg_rdata or the address.
  int          cfg_wait;
  logic [DW-1:0] cfg_rdata;
  logic        cfg_err;
  logic        cfg_use_addr;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
      bus.pready  = (cfg_wait >= 0) && (acc_cnt == cfg_wait);
      bus.prdata  = cfg_use_addr ? DW'(bus.paddr) : cfg_rdata;
      bus.pslverr = cfg_err;
      acc_cnt++;
    end else begin
      bus.pready  = 1'b0;
      bus.prdata  = '0;
      bus.pslverr = 1'b0;
      acc_cnt     = 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("send_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus.rsp_valid !== 1'b1 && edges < budget);
    if (bus.rsp_valid !== 1'b1) check("rsp_wait", 64'(bus.rsp_valid), 64'd1);
  endtask

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_cycles;
    logic [DW-1:0] prdata;
    logic          pslverr;
    rsp_t          exp;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int ws, input logic [DW-1:0] pr, input logic pe,
                              input logic [DW-1:0] er, input logic ee, input logic et,
                              input int lat);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wait_cycles = ws;
    v.prdata = pr; v.pslverr = pe;
    v.exp.rdata = er; v.exp.error = ee; v.exp.timeout = et;
    v.exp_lat = lat;
    return v;
  endfunction

  // One transfer: issue, watch APB phases and fields, time the response.
  task automatic run_vec(input int idx, input vec_t v);
    int  edges;
    bit  seen;
    bit  apb_bad;
    cfg_wait = v.wait_cycles;
    cfg_rdata = v.prdata;
    cfg_err = v.pslverr;
    cfg_use_addr = 1'b0;
    send(v.write, v.addr, v.wdata);
    edges = 0;
    seen = 1'b0;
    apb_bad = 1'b0;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      if (bus.psel === 1'b1 &&
          (bus.paddr !== v.addr || bus.pwrite !== v.write || bus.pwdata !== v.wdata))
        apb_bad = 1'b1;
      if (edges == 1 && !(bus.psel === 1'b1 && bus.penable === 1'b0)) apb_bad = 1'b1;
      if (edges == 2 && !(bus.psel === 1'b1 && bus.penable === 1'b1)) apb_bad = 1'b1;
      seen = (bus.rsp_valid === 1'b1);
      if (seen && bus.psel !== 1'b0) apb_bad = 1'b1;
    end
    $display("txn %0d %s addr=%05h lat=%0d rdata=%08h err=%0b tmo=%0b", idx,
             v.write ? "WR" : "RD", v.addr, edges, bus.rsp_rdata, bus.rsp_error, bus.rsp_timeout);
    check($sformatf("v%0d_latency", idx), 64'(edges), 64'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), 64'(bus.rsp_rdata), 64'(v.exp.rdata));
    check($sformatf("v%0d_error", idx), 64'(bus.rsp_error), 64'(v.exp.error));
    check($sformatf("v%0d_timeout", idx), 64'(bus.rsp_timeout), 64'(v.exp.timeout));
    check($sformatf("v%0d_apb_phases", idx), 64'(apb_bad), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_cleared", idx), 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int  e;
    int  accepts;
    bit  rdy;
    bit  psel_seen;
    bit  stable_bad;

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    cfg_wait = 0;
    cfg_rdata = '0;
    cfg_err = 1'b0;
    cfg_use_addr = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_psel", 64'(bus.psel), 64'd0);
    check("rst_penable", 64'(bus.penable), 64'd0);
    check("rst_pwrite", 64'(bus.pwrite), 64'd0);
    check("rst_paddr", 64'(bus.paddr), 64'd0);
    check("rst_pwdata", 64'(bus.pwdata), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    //            wr    addr        wdata         wait prdata        err  exp rdata     err  tmo  lat
    vecs[0] = mk(1'b0, 20'h00010, 32'h0000_0000,  0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 3);
    vecs[1] = mk(1'b1, 20'h00104, 32'h1234_5678,  2, 32'hFFFF0000, 1'b1, 32'h00000000, 1'b1, 1'b0, 5);
    vecs[2] = mk(1'b0, 20'hFFFFC, 32'h0000_0001,  1, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b0, 1'b0, 4);
    vecs[3] = mk(1'b1, 20'h80000, 32'hCAFE_F00D,  0, 32'h11111111, 1'b0, 32'h00000000, 1'b0, 1'b0, 3);
    vecs[4] = mk(1'b0, 20'h00200, 32'h0000_0000, -1, 32'h77777777, 1'b0, 32'h00000000, 1'b1, 1'b1, 19);
    vecs[5] = mk(1'b0, 20'h00204, 32'h0000_0000, 16, 32'h13579BDF, 1'b0, 32'h13579BDF, 1'b0, 1'b0, 19);
    vecs[6] = mk(1'b0, 20'h00208, 32'h0000_0000, 15, 32'h2468ACE0, 1'b0, 32'h2468ACE0, 1'b0, 1'b0, 18);
    vecs[7] = mk(1'b1, 20'h0020C, 32'h0BAD_F00D, -1, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 19);
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-pressure: pending response blocks pops, FIFO fills at four.
    cfg_wait = 0;
    cfg_err = 1'b0;
    cfg_use_addr = 1'b1;
    bus.rsp_ready = 1'b0;
    send(1'b0, 20'h00AAA, 32'h0);
    wait_rsp(10, e);
    accepts = 0;
    psel_seen = 1'b0;
    stable_bad = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 20'h00100;
    for (int c = 0; c < 10; c++) begin
      rdy = bus.cmd_ready;
      tick();
      if (rdy) begin
        accepts++;
        bus.cmd_addr = AW'(32'h100 + accepts);
      end
      if (bus.psel === 1'b1) psel_seen = 1'b1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h00000AAA ||
          bus.rsp_error !== 1'b0 || bus.rsp_timeout !== 1'b0) stable_bad = 1'b1;
    end
    $display("fill accepts=%0d cmd_ready=%0b", accepts, bus.cmd_ready);
    check("fill_accepts", 64'(accepts), 64'd4);
    check("fill_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
    check("stall_no_setup", 64'(psel_seen), 64'd0);
    check("stall_rsp_stable", 64'(stable_bad), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("handshake_rsp_cleared", 64'(bus.rsp_valid), 64'd0);
    check("handshake_no_setup_yet", 64'(bus.psel), 64'd0);
    tick();
    check("setup_after_handshake", 64'({bus.psel, bus.penable}), 64'b10);
    check("fifth_slot_open", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(30, e);
      $display("fill rsp %0d rdata=%08h gap=%0d", j, bus.rsp_rdata, e);
      check($sformatf("order_rsp%0d", j), 64'(bus.rsp_rdata), 64'(32'h100 + j));
      if (j > 0) check($sformatf("throughput_gap%0d", j), 64'(e), 64'd4);
    end

    // Reset during ACCESS with a second command queued behind it.
    cfg_wait = 6;
    send(1'b0, 20'h00C00, 32'h0);
    send(1'b1, 20'h00C04, 32'h55AA55AA);
    e = 0;
    while (bus.penable !== 1'b1 && e < 20) begin
      tick();
      e++;
    end
    check("reach_access", 64'(bus.penable), 64'd1);
    rst = 1'b1;
    tick();
    $display("midrst psel=%0b penable=%0b rsp_valid=%0b cmd_ready=%0b",
             bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready);
    check("midrst_psel", 64'(bus.psel), 64'd0);
    check("midrst_penable", 64'(bus.penable), 64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("midrst_release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    psel_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.psel === 1'b1 || bus.rsp_valid === 1'b1) psel_seen = 1'b1;
    end
    check("midrst_fifo_flushed", 64'(psel_seen), 64'd0);
    cfg_wait = 0;
    send(1'b0, 20'h00C08, 32'h0);
    wait_rsp(30, e);
    $display("post-reset txn rdata=%08h lat=%0d", bus.rsp_rdata, e);
    check("post_rst_latency", 64'(e), 64'd3);
    check("post_rst_rdata", 64'(bus.rsp_rdata), 64'h00000C08);
    check("post_rst_error", 64'(bus.rsp_error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
